// File: rtl/pcp_pair_combiner.sv
// pcp_pair_combiner
//   Pairs incoming AXI4-Stream beats as (index, value) and emits one combined
//   record {value, index} per pair into a 1-deep output register. A vector of
//   VEC_LEN records is closed by s_tlast on the final value beat, and that
//   record carries m_tlast. The index sequence and framing are checked, with
//   sticky error flags and a wrapping completed-vector counter.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_tdata/tvalid/      input stream; only the low IDX_W (index beat) or
//   tready/tlast         VAL_W (value beat) bits are used
//   m_tdata/tvalid/      output record stream, {value, index} with the index
//   tready/tlast         in the low bits
//   clr_status           synchronous clear of err_* and vec_count
//   err_seq              sticky: index beat differed from the expected index
//   err_frame            sticky: s_tlast seen on an index beat
//   err_len              sticky: vector length differed from VEC_LEN
//   vec_count            completed vectors (closed by s_tlast), wrapping
module pcp_pair_combiner #(
  parameter int DATA_WIDTH = 512,
  parameter int IDX_W      = 8,
  parameter int VAL_W      = 8,
  parameter int VEC_LEN    = 12,
  parameter int CNT_W      = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  output logic [IDX_W+VAL_W-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  input  logic                   clr_status,
  output logic                   err_seq,
  output logic                   err_frame,
  output logic                   err_len,
  output logic [CNT_W-1:0]       vec_count
);

  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] VEC_LEN_C = IDX_W'(VEC_LEN);

  typedef enum logic {ST_IDX, ST_VAL} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             run_q;     // low through reset, so s_tready stays low until the first edge after release
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] exp_idx;
  logic [IDX_W-1:0] pair_cnt;
  logic [IDX_W-1:0] pair_inc;
  logic             idx_acc;
  logic             val_acc;
  logic             seq_evt;
  logic             frame_evt;
  logic             len_evt;
  logic             vec_end;
  logic             pair_wrap;
  logic             unused_tdata;

  // Upper data bits carry no meaning for this block.
  assign unused_tdata = ^s_tdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDX;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_tready  = 1'b0;
    case (state)
      ST_IDX: begin
        s_tready = run_q;
        if (s_tvalid && run_q) state_nxt = ST_VAL;
      end
      ST_VAL: begin
        // Loading is allowed when the output register is empty or draining
        // this cycle, giving one record every two beats without bubbles.
        s_tready = run_q && (!m_tvalid || m_tready);
        if (s_tvalid && run_q && (!m_tvalid || m_tready)) state_nxt = ST_IDX;
      end
      default: state_nxt = ST_IDX;
    endcase
  end

  assign idx_acc   = (state == ST_IDX) && s_tvalid && s_tready;
  assign val_acc   = (state == ST_VAL) && s_tvalid && s_tready;
  assign pair_inc  = pair_cnt + IDX_ONE;
  assign seq_evt   = idx_acc && (s_tdata[IDX_W-1:0] != exp_idx);
  assign frame_evt = idx_acc && s_tlast;
  assign vec_end   = val_acc && s_tlast;
  assign pair_wrap = val_acc && (s_tlast || (pair_inc == VEC_LEN_C));
  // Early tlast, late tlast and missing tlast all count as a length error.
  assign len_evt   = vec_end ? (pair_inc != VEC_LEN_C)
                             : (val_acc && (pair_inc == VEC_LEN_C));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q     <= 1'b0;
      idx_q     <= '0;
      exp_idx   <= IDX_ONE;
      pair_cnt  <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      err_seq   <= 1'b0;
      err_frame <= 1'b0;
      err_len   <= 1'b0;
      vec_count <= '0;
    end else begin
      run_q <= 1'b1;

      // Stage boundary: index beat captured, waiting for its value beat.
      if (idx_acc) idx_q <= s_tdata[IDX_W-1:0];

      // Stage boundary: combined record into the output register. A load in
      // the same cycle as a transfer keeps m_tvalid high.
      if (val_acc) begin
        m_tdata  <= {s_tdata[VAL_W-1:0], idx_q};
        m_tvalid <= 1'b1;
        m_tlast  <= s_tlast;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      if (pair_wrap) begin
        pair_cnt <= '0;
        exp_idx  <= IDX_ONE;
      end else if (val_acc) begin
        pair_cnt <= pair_inc;
        exp_idx  <= exp_idx + IDX_ONE;
      end

      // An error event in the clearing cycle keeps its flag set.
      err_seq   <= (err_seq   && !clr_status) || seq_evt;
      err_frame <= (err_frame && !clr_status) || frame_evt;
      err_len   <= (err_len   && !clr_status) || len_evt;

      // A vector closing in the clearing cycle is still counted.
      if (clr_status)   vec_count <= vec_end ? CNT_W'(1) : '0;
      else if (vec_end) vec_count <= vec_count + CNT_W'(1);
    end
  end

endmodule
